// File: rtl/decoder8_grant.sv
// Registered 3-to-8 grant decoder: turns an encoder (n, g) pair into a held
// one-hot grant, released by requester ack or by a programmable hold window.
module decoder8_grant #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ena,
  input  logic              g,
  input  logic [2:0]        n,
  input  logic [HOLD_W-1:0] hold,
  input  logic              ack,
  output logic              ready,
  output logic [7:0]        y,
  output logic [2:0]        idx,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_REL   = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] CNT_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [7:0]        y_q, y_d;
  logic [2:0]        idx_q, idx_d;
  logic              done_q, done_d;
  logic              to_q, to_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    done_d  = done_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (ena && g) begin
          idx_d   = n;
          y_d     = 8'b1 << n;
          hold_d  = hold;
          cnt_d   = hold;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // ack wins over a window that expires in the same cycle
        if (ack) begin
          state_d = S_REL;
          y_d     = 8'h00;
          done_d  = 1'b1;
          to_d    = 1'b0;
        end else if (hold_q != '0) begin
          if (cnt_q == CNT_ONE) begin
            state_d = S_REL;
            y_d     = 8'h00;
            done_d  = 1'b1;
            to_d    = 1'b1;
          end else if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      S_REL: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        to_d    = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        y_d     = 8'h00;
        done_d  = 1'b0;
        to_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      y_q     <= 8'h00;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q != S_IDLE);
  assign y       = y_q;
  assign idx     = idx_q;
  assign done    = done_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_decoder8_grant.sv
// Directed-vector bench for decoder8_grant: ack release, window expiry,
// gating, async reset and back-to-back grants.
module tb_decoder8_grant;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ena, g, ack;
  logic [2:0] n;
  logic [3:0] hold;
  logic       ready, busy, done, timeout;
  logic [7:0] y;
  logic [2:0] idx;

  int vecs = 0;
  int errs = 0;

  decoder8_grant #(.HOLD_W(4)) dut (
    .clk(clk), .clrn(clrn), .ena(ena), .g(g), .n(n),
    .hold(hold), .ack(ack), .ready(ready), .y(y), .idx(idx),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t want finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; ena = 0; g = 0; ack = 0; n = 0; hold = 0;
    #12;
    vecs++;
    if (y !== 8'h00 || idx !== 3'd0 || ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || timeout !== 1'b0) begin
      errs++;
      $display("FAIL reset: y=%h idx=%0d rdy=%b busy=%b done=%b to=%b want 00 0 1 0 0 0",
               y, idx, ready, busy, done, timeout);
    end
    tick();
    clrn = 1'b1;
    tick();
  endtask

  task automatic test_ack_release();
    ena = 1; g = 1; n = 3'd5; hold = 4'd0; ack = 0;
    tick();
    g = 0;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (y !== 8'h20 || busy !== 1'b1 || done !== 1'b0) begin
        errs++;
        $display("FAIL ack_grant[%0d]: y=%h busy=%b done=%b want 20 1 0", i, y, busy, done);
      end
      if (i == 3) ack = 1;
      tick();
    end
    ack = 0;
    vecs++;
    if (y !== 8'h00 || done !== 1'b1 || timeout !== 1'b0 || ready !== 1'b0) begin
      errs++;
      $display("FAIL ack_release: y=%h done=%b to=%b rdy=%b want 00 1 0 0", y, done, timeout, ready);
    end
    tick();
    vecs++;
    if (ready !== 1'b1 || idx !== 3'd5 || done !== 1'b0 || y !== 8'h00) begin
      errs++;
      $display("FAIL ack_idle: rdy=%b idx=%0d done=%b y=%h want 1 5 0 00", ready, idx, done, y);
    end
  endtask

  task automatic test_timeout();
    ena = 1; g = 1; n = 3'd2; hold = 4'd3; ack = 0;
    tick();
    g = 0; hold = 4'd9;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (y !== 8'h04 || done !== 1'b0) begin
        errs++;
        $display("FAIL to_grant[%0d]: y=%h done=%b want 04 0", i, y, done);
      end
      tick();
    end
    vecs++;
    if (y !== 8'h00 || done !== 1'b1 || timeout !== 1'b1) begin
      errs++;
      $display("FAIL to_release: y=%h done=%b to=%b want 00 1 1", y, done, timeout);
    end
    tick();
    vecs++;
    if (ready !== 1'b1 || done !== 1'b0 || timeout !== 1'b0 || idx !== 3'd2) begin
      errs++;
      $display("FAIL to_idle: rdy=%b done=%b to=%b idx=%0d want 1 0 0 2", ready, done, timeout, idx);
    end
  endtask

  task automatic test_ack_vs_expiry();
    ena = 1; g = 1; n = 3'd0; hold = 4'd1; ack = 0;
    tick();
    g = 0;
    vecs++;
    if (y !== 8'h01) begin
      errs++;
      $display("FAIL tie_grant: y=%h want 01", y);
    end
    ack = 1;
    tick();
    ack = 0;
    vecs++;
    if (y !== 8'h00 || done !== 1'b1 || timeout !== 1'b0) begin
      errs++;
      $display("FAIL tie_release: y=%h done=%b to=%b want 00 1 0", y, done, timeout);
    end
    tick();
  endtask

  task automatic test_gating();
    ena = 0; g = 1; n = 3'd6; hold = 4'd2; ack = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin ena = 1; g = 0; end
      tick();
      vecs++;
      if (y !== 8'h00 || ready !== 1'b1 || busy !== 1'b0) begin
        errs++;
        $display("FAIL gating[%0d]: y=%h rdy=%b busy=%b want 00 1 0", i, y, ready, busy);
      end
    end
    ack = 0;
  endtask

  task automatic test_async_reset();
    ena = 1; g = 1; n = 3'd7; hold = 4'd0; ack = 0;
    tick();
    n = 3'd1;
    for (int i = 0; i < 3; i++) begin
      g = ~g;
      vecs++;
      if (y !== 8'h80 || idx !== 3'd7) begin
        errs++;
        $display("FAIL hold_grant[%0d]: y=%h idx=%0d want 80 7", i, y, idx);
      end
      tick();
    end
    ena = 0;
    #2 clrn = 1'b0;
    #1;
    vecs++;
    if (y !== 8'h00 || idx !== 3'd0 || ready !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL arst_grant: y=%h idx=%0d rdy=%b done=%b want 00 0 1 0", y, idx, ready, done);
    end
    tick();
    clrn = 1'b1;
    ena = 1; g = 1; n = 3'd3; hold = 4'd1;
    tick();
    g = 0;
    tick();
    vecs++;
    if (done !== 1'b1 || timeout !== 1'b1) begin
      errs++;
      $display("FAIL pre_arst_rel: done=%b to=%b want 1 1", done, timeout);
    end
    #2 clrn = 1'b0;
    #1;
    vecs++;
    if (done !== 1'b0 || timeout !== 1'b0 || ready !== 1'b1 || y !== 8'h00) begin
      errs++;
      $display("FAIL arst_rel: done=%b to=%b rdy=%b y=%h want 0 0 1 00", done, timeout, ready, y);
    end
    tick();
    clrn = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    ena = 1; g = 1; hold = 4'd2; ack = 0;
    for (int k = 0; k < 8; k++) begin
      n = 3'(k);
      exp = 8'b1 << k;
      for (int c = 0; c < 4; c++) begin
        tick();
        vecs++;
        if (!$onehot0(y)) begin
          errs++;
          $display("FAIL onehot[%0d.%0d]: y=%h want <=1 bit", k, c, y);
        end
        vecs++;
        case (c)
          0, 1: if (y !== exp || idx !== 3'(k) || busy !== 1'b1) begin
            errs++;
            $display("FAIL b2b_grant[%0d.%0d]: y=%h idx=%0d want %h %0d", k, c, y, idx, exp, k);
          end
          2: if (y !== 8'h00 || done !== 1'b1 || timeout !== 1'b1) begin
            errs++;
            $display("FAIL b2b_rel[%0d]: y=%h done=%b to=%b want 00 1 1", k, y, done, timeout);
          end
          default: if (y !== 8'h00 || ready !== 1'b1 || done !== 1'b0) begin
            errs++;
            $display("FAIL b2b_idle[%0d]: y=%h rdy=%b done=%b want 00 1 0", k, y, ready, done);
          end
        endcase
      end
    end
    g = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ack_release();
    test_timeout();
    test_ack_vs_expiry();
    test_gating();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/decoder8_grant.md
Name: decoder8_grant

Overview:
- Registered 3-to-8 grant decoder: the consumer side of the 8-input priority encoder's (n, g) output.
- Accepts an encoded winner index with a valid qualifier and drives a one-hot grant line to the selected requester.
- Holds the grant until the requester acknowledges it or a programmable hold window expires, then signals completion.
- Sits between the interrupt/request priority encoder and the eight requesting units.

Parameters:
HOLD_W, 4, width of hold-window count and internal down-counter (max window 2^HOLD_W-1 cycles)

Ports:
clk  input  1  rising-edge clock
clrn  input  1  asynchronous active-low reset
ena  input  1  block enable; requests ignored while 0
g  input  1  request valid (encoder "any input active")
n  input  3  encoded index of winning requester
hold  input  HOLD_W  grant window in cycles; 0 = no timeout, wait for ack
ack  input  1  requester acknowledge, sampled only in GRANT
ready  output  1  block can accept a request (state==IDLE)
y  output  8  one-hot grant, registered
idx  output  3  registered index of current/last grant
busy  output  1  state!=IDLE
done  output  1  one-cycle pulse on grant release
timeout  output  1  valid with done; 1 = released by window expiry, 0 = released by ack

Behaviour:
- Reset (clrn=0, async): state=IDLE, y=0, idx=0, done=0, timeout=0, internal cnt=0, hold_q=0. busy=0 and ready=1 follow from IDLE.
- States: IDLE, GRANT, RELEASE; 2-bit encoding, registered.
- IDLE: ready=1, y=0. Capture occurs at a rising edge with ena&g=1. At capture: idx<=n, y<=8'b1<<n, hold_q<=hold, cnt<=hold, state<=GRANT. There is no capture if ena=0 or g=0. ack in IDLE is ignored.
- Latency: y is one-hot in the first cycle after the capture edge, so request to grant is 1 cycle.
- GRANT: y holds a single bit, 1<<idx. n, g and hold changes are ignored. At each edge:
  - ack=1: state<=RELEASE, timeout<=0. ack has priority over expiry in the same cycle.
  - ack=0, hold_q!=0, cnt==1: state<=RELEASE, timeout<=1.
  - ack=0, hold_q!=0, cnt>1: cnt<=cnt-1.
  - ack=0, hold_q==0: remain in GRANT indefinitely.
- Grant duration with no ack is exactly hold_q cycles of y asserted.
- RELEASE: lasts one cycle. y=0, done=1, and timeout is held from the transition. The next edge sets state<=IDLE, done<=0, timeout<=0. ready=0 during RELEASE, so back-to-back grants are separated by at least one idle-y cycle.
- ena deasserted during GRANT does not abort the grant. It only blocks new captures.
- idx retains its last granted value through RELEASE and IDLE until the next capture.
- Invariant: y is always 0 or exactly one-hot; y!=0 only in GRANT.
- Reset asserted mid-GRANT or mid-RELEASE: y=0 and done=0 immediately (asynchronous), and the block returns to IDLE.
- Width: cnt is HOLD_W bits and never underflows (it is loaded, then decremented only while >1).

Test Plan:
1. Reset, then ena=1, g=1, n=5, hold=0; ack after 3 cycles -> y=8'h20 from the cycle after capture for 4 cycles, then one cycle y=0 with done=1, timeout=0, then ready=1, idx=5.
2. ena=1, g=1, n=2, hold=3, ack=0 -> y=8'h04 for exactly 3 cycles, then done=1, timeout=1 for one cycle, then IDLE.
3. hold=1, n=0, ack=1 in the first GRANT cycle (simultaneous with expiry) -> y=8'h01 for 1 cycle, done=1, timeout=0.
4. g=1 with ena=0, then ena=1 with g=0, for 5 cycles each -> no capture; y=0, ready=1, busy=0 throughout.
5. During GRANT with n=7, change n to 1 and toggle g, then assert clrn=0 mid-grant -> y remains 8'h80 until reset, then y=0, idx=0, ready=1 asynchronously without waiting for a clock edge.
6. Requests for n=0..7 back-to-back with g held high, hold=2, no ack -> each y=1<<n for 2 cycles, a single RELEASE cycle between grants, and the next capture on the IDLE cycle. Check the one-hot invariant every cycle.
